load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/lsu_load_align.sv | 34 +++
 rtl/load_store_unit.sv | 138 +++++++++++++
 tb/tb_load_store_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   size_e  : CPU access size encoding (byte/half/word/double)
//   state_e : sequencing FSM states
//   BE_*    : byte-enable patterns for the 32-bit memory word
//   is_misaligned() : natural-alignment test for a given size
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'd0,
    SZ_HALF   = 2'd1,
    SZ_WORD   = 2'd2,
    SZ_DOUBLE = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE0,
    CAP0,
    ISSUE1,
    CAP1,
    RESP
  } state_e;

  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_ALL     = 4'b1111;

  // Every access must be naturally aligned to its own size.
  function automatic logic is_misaligned(input size_e size, input logic [2:0] addr_lo);
    case (size)
      SZ_HALF:   return addr_lo[0];
      SZ_WORD:   return addr_lo[1:0] != 2'b00;
      SZ_DOUBLE: return addr_lo != 3'b000;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-data aligner.
//   size_i    : access size (size_e encoding)
//   signed_i  : 1 = sign-extend, 0 = zero-extend (ignored for double)
//   offset_i  : byte offset of the access within the memory word
//   lo_word_i : memory word holding the lane (low word of a double)
//   hi_word_i : high word of a double load
//   result_o  : 64-bit right-aligned, extended load result
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] lo_word_i,
  input  logic [31:0] hi_word_i,
  output logic [63:0] result_o
);

  logic [31:0] shifted;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    shifted  = lo_word_i >> {offset_i, 3'b000};
    result_o = '0;
    case (size_e'(size_i))
      SZ_BYTE: result_o = {{56{signed_i & shifted[7]}},  shifted[7:0]};
      SZ_HALF: result_o = {{48{signed_i & shifted[15]}}, shifted[15:0]};
      SZ_WORD: result_o = {{32{signed_i & shifted[31]}}, shifted};
      default: result_o = {hi_word_i, lo_word_i};  // double: little-endian pair
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns one CPU access into one or two 32-bit memory
// transactions, then pulses oDone with the aligned/extended load result.
//   iCLK, iRST_n            : clock, synchronous active-low reset
//   iReq .. iWData          : CPU request (sampled only while oReady=1)
//   oReady, oDone           : idle indicator, one-cycle completion pulse
//   oMisaligned, oRData     : completion qualifiers (reject flag, load data)
//   oMemRead .. oMemWData   : memory-side strobes, lanes, word address
//   iMemRData               : memory read data, valid the cycle after oMemRead
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic              iReq,
  input  logic              iWrite,
  input  logic [1:0]        iSize,
  input  logic              iSigned,
  input  logic [ADDR_W-1:0] iAddr,
  input  logic [DATA_W-1:0] iWData,
  output logic              oReady,
  output logic              oDone,
  output logic              oMisaligned,
  output logic [DATA_W-1:0] oRData,
  output logic              oMemRead,
  output logic              oMemWrite,
  output logic [3:0]        oByteEnable,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oMemWData,
  input  logic [DATA_W-1:0] iMemRData
);

  state_e            state_q, state_d;
  logic              write_q, signed_q, mis_q;
  size_e             size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       wdata_q;
  logic [31:0]       lo_q;
  logic [63:0]       rdata_q;

  logic              accept;
  logic              last_cap;
  logic [ADDR_W-1:0] word_addr;
  logic [31:0]       lanes;
  logic [63:0]       load_result;

  assign accept    = (state_q == IDLE) && iReq;
  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};
  // The result register is written only on the final capture, so oRData
  // stays stable through the intermediate states of a double load.
  assign last_cap  = (state_q == CAP1) || (state_q == CAP0 && size_q != SZ_DOUBLE);

  lsu_load_align u_align (
    .size_i    (size_q),
    .signed_i  (signed_q),
    .offset_i  (addr_q[1:0]),
    .lo_word_i ((state_q == CAP1) ? lo_q : iMemRData[31:0]),
    .hi_word_i (iMemRData[31:0]),
    .result_o  (load_result)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (iReq) state_d = is_misaligned(size_e'(iSize), iAddr[2:0]) ? RESP : ISSUE0;
      ISSUE0:  if (!write_q)                 state_d = CAP0;
               else if (size_q == SZ_DOUBLE) state_d = ISSUE1;
               else                          state_d = RESP;
      CAP0:    state_d = (size_q == SZ_DOUBLE) ? ISSUE1 : RESP;
      ISSUE1:  state_d = write_q ? RESP : CAP1;
      CAP1:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      mis_q    <= 1'b0;
      size_q   <= SZ_BYTE;
      addr_q   <= '0;
      wdata_q  <= '0;
      lo_q     <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q  <= iWrite;
        signed_q <= iSigned;
        size_q   <= size_e'(iSize);
        mis_q    <= is_misaligned(size_e'(iSize), iAddr[2:0]);
        addr_q   <= iAddr;
        wdata_q  <= 64'(iWData);
      end
      if (state_q == CAP0) lo_q    <= iMemRData[31:0];
      if (last_cap)        rdata_q <= load_result;
    end
  end

  always_comb begin
    oMemRead    = 1'b0;
    oMemWrite   = 1'b0;
    oByteEnable = '0;
    oMemAddr    = '0;
    oMemWData   = '0;
    lanes       = '0;
    case (size_q)
      SZ_BYTE:   lanes = {4{wdata_q[7:0]}};
      SZ_HALF:   lanes = {2{wdata_q[15:0]}};
      SZ_WORD:   lanes = wdata_q[31:0];
      default:   lanes = (state_q == ISSUE1) ? wdata_q[63:32] : wdata_q[31:0];
    endcase
    if (state_q == ISSUE0 || state_q == ISSUE1) begin
      oMemRead  = !write_q;
      oMemWrite = write_q;
      oMemAddr  = word_addr + ((state_q == ISSUE1) ? ADDR_W'(4) : ADDR_W'(0));
      case (size_q)
        SZ_BYTE: oByteEnable = BE_BYTE0 << addr_q[1:0];
        SZ_HALF: oByteEnable = addr_q[1] ? BE_HI_HALF : BE_LO_HALF;
        default: oByteEnable = BE_ALL;
      endcase
      if (write_q) oMemWData = DATA_W'(lanes);
    end
  end

  assign oReady      = (state_q == IDLE);
  assign oDone       = (state_q == RESP);
  assign oMisaligned = (state_q == RESP) && mis_q;
  assign oRData      = DATA_W'(rdata_q);

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios, randomized
// accesses against a behavioural memory/result model, reset and back-to-back.
module tb_load_store_unit;

  logic        iCLK = 1'b0;
  logic        iRST_n, iReq, iWrite, iSigned;
  logic [1:0]  iSize;
  logic [63:0] iAddr, iWData, iMemRData;
  logic        oReady, oDone, oMisaligned, oMemRead, oMemWrite;
  logic [63:0] oRData, oMemAddr, oMemWData;
  logic [3:0]  oByteEnable;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [longint];   // model memory, keyed by word address
  logic [63:0] last_rdata = '0; // model of the held oRData value

  always #5 iCLK = ~iCLK;

  load_store_unit dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iReq(iReq), .iWrite(iWrite), .iSize(iSize),
    .iSigned(iSigned), .iAddr(iAddr), .iWData(iWData), .oReady(oReady),
    .oDone(oDone), .oMisaligned(oMisaligned), .oRData(oRData),
    .oMemRead(oMemRead), .oMemWrite(oMemWrite), .oByteEnable(oByteEnable),
    .oMemAddr(oMemAddr), .oMemWData(oMemWData), .iMemRData(iMemRData)
  );

  function automatic logic [31:0] rd_mem(input logic [63:0] a);
    return mem.exists(longint'(a)) ? mem[longint'(a)] : 32'h0;
  endfunction

  // One complete access: drive, act as memory, record, compare to model.
  task automatic run_access(input bit wr, input logic [1:0] sz, input bit sg,
                            input logic [63:0] a, input logic [63:0] wd, input string name);
    logic [63:0] base, exp_rd, v, mask, got_rd, prev_addr;
    logic [31:0] e_wd, w;
    logic [3:0]  e_be;
    bit mis, got_mis, prev_rd;
    int off, nw, lat, bits, done_cyc, ns, e_cyc;
    int s_cyc[4]; bit s_rd[4]; logic [63:0] s_addr[4]; logic [3:0] s_be[4]; logic [31:0] s_wd[4];

    off  = int'(a[1:0]);
    base = a & ~64'h3;
    mis  = (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 0) || (sz == 2'd3 && a[2:0] != 0);
    nw   = (sz == 2'd3) ? 2 : 1;
    lat  = mis ? 1 : (wr ? 1 + nw : 1 + 2 * nw);
    if (mis || wr) exp_rd = last_rdata;
    else if (sz == 2'd3) exp_rd = {rd_mem(base + 4), rd_mem(base)};
    else begin
      bits = 8 << sz;
      v    = {32'h0, rd_mem(base)} >> (off * 8);
      mask = (64'h1 << bits) - 1;
      v    = v & mask;
      if (sg && v[bits-1]) v = v | ~mask;
      exp_rd = v;
    end

    @(negedge iCLK);
    iReq = 1'b1; iWrite = wr; iSize = sz; iSigned = sg; iAddr = a; iWData = wd;
    vectors++;
    if (oReady !== 1'b1) begin miscompares++; $display("FAIL %s ready_before: got %b want 1", name, oReady); end

    done_cyc = 0; ns = 0; prev_rd = 1'b0; prev_addr = '0; got_mis = 1'b0; got_rd = '0;
    for (int c = 1; c <= 12 && done_cyc == 0; c++) begin
      @(negedge iCLK);
      if (c == 1) begin  // scramble inputs: the accepted request must be latched
        iReq = 1'b0; iWrite = 1'($urandom); iSize = 2'($urandom); iSigned = 1'($urandom);
        iAddr = {$urandom, $urandom}; iWData = {$urandom, $urandom};
      end
      iMemRData = prev_rd ? {$urandom, rd_mem(prev_addr)} : {$urandom, $urandom};
      prev_rd = oMemRead; prev_addr = oMemAddr;
      if ((oMemRead || oMemWrite) && ns < 4) begin
        s_cyc[ns] = c; s_rd[ns] = oMemRead; s_addr[ns] = oMemAddr;
        s_be[ns] = oByteEnable; s_wd[ns] = oMemWData[31:0]; ns++;
      end
      vectors++;
      if (oReady !== 1'b0) begin miscompares++; $display("FAIL %s ready_busy c%0d: got %b want 0", name, c, oReady); end
      if (oDone === 1'b1) begin
        done_cyc = c; got_mis = oMisaligned; got_rd = oRData;
      end else begin
        vectors++;
        if (oMisaligned !== 1'b0 || oRData !== last_rdata) begin
          miscompares++;
          $display("FAIL %s hold c%0d: mis=%b rdata=%h want mis=0 rdata=%h", name, c, oMisaligned, oRData, last_rdata);
        end
      end
    end

    vectors++;
    if (done_cyc != lat) begin miscompares++; $display("FAIL %s latency: got %0d want %0d", name, done_cyc, lat); end
    vectors++;
    if (got_mis !== mis) begin miscompares++; $display("FAIL %s misaligned: got %b want %b", name, got_mis, mis); end
    vectors++;
    if (got_rd !== exp_rd) begin miscompares++; $display("FAIL %s rdata: got %h want %h", name, got_rd, exp_rd); end
    vectors++;
    if (ns != (mis ? 0 : nw)) begin miscompares++; $display("FAIL %s strobe_count: got %0d want %0d", name, ns, mis ? 0 : nw); end

    for (int i = 0; i < ns && i < nw && !mis; i++) begin
      e_cyc = wr ? 1 + i : 1 + 2 * i;
      e_be  = (sz == 2'd0) ? 4'(1 << off) : (sz == 2'd1) ? (a[1] ? 4'hC : 4'h3) : 4'hF;
      e_wd  = (sz == 2'd0) ? {4{wd[7:0]}} : (sz == 2'd1) ? {2{wd[15:0]}} : (i == 1 ? wd[63:32] : wd[31:0]);
      vectors++;
      if (s_cyc[i] != e_cyc || s_rd[i] !== !wr || s_addr[i] !== base + 64'(4 * i) || s_be[i] !== e_be ||
          (wr && s_wd[i] !== e_wd)) begin
        miscompares++;
        $display("FAIL %s strobe%0d: got c%0d rd=%b addr=%h be=%b wd=%h want c%0d rd=%b addr=%h be=%b wd=%h",
                 name, i, s_cyc[i], s_rd[i], s_addr[i], s_be[i], s_wd[i], e_cyc, !wr, base + 64'(4 * i), e_be, e_wd);
      end
      if (wr) begin
        w = rd_mem(base + 64'(4 * i));
        for (int b = 0; b < 4; b++) if (e_be[b]) w[8*b +: 8] = e_wd[8*b +: 8];
        mem[longint'(base + 64'(4 * i))] = w;
      end
    end

    @(negedge iCLK);
    vectors++;
    if (oReady !== 1'b1 || oDone !== 1'b0) begin
      miscompares++; $display("FAIL %s after: ready=%b done=%b want 1/0", name, oReady, oDone);
    end
    last_rdata = exp_rd;
  endtask

  task automatic test_reset();
    iRST_n = 1'b0;
    repeat (2) @(negedge iCLK);
    vectors++;
    if (oReady !== 1'b1 || oDone !== 1'b0 || oMisaligned !== 1'b0 || oMemRead !== 1'b0 ||
        oMemWrite !== 1'b0 || oByteEnable !== 4'h0 || oMemAddr !== 64'h0 || oMemWData !== 64'h0 ||
        oRData !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_state: ready=%b done=%b mis=%b rd=%b wr=%b be=%b addr=%h wd=%h rdata=%h want 1,0,...,0",
               oReady, oDone, oMisaligned, oMemRead, oMemWrite, oByteEnable, oMemAddr, oMemWData, oRData);
    end
    iRST_n = 1'b1;
    last_rdata = '0;
  endtask

  task automatic test_directed();
    mem[64'h1000] = 32'h80FF7F01;
    mem[64'h1008] = 32'h11111111;
    mem[64'h100C] = 32'h22222222;
    run_access(1'b0, 2'd0, 1'b1, 64'h1002, 64'h0, "load_byte_signed");
    run_access(1'b1, 2'd1, 1'b0, 64'h1002, 64'hBEEF, "store_half");
    run_access(1'b0, 2'd2, 1'b0, 64'h1000, 64'h0, "load_word_after_store");
    run_access(1'b0, 2'd3, 1'b0, 64'h1008, 64'h0, "load_double");
    run_access(1'b0, 2'd2, 1'b0, 64'h1001, 64'h0, "load_word_misaligned");
    run_access(1'b1, 2'd3, 1'b0, 64'h1010, 64'hCAFEF00D_DEADBEEF, "store_double");
    run_access(1'b0, 2'd1, 1'b1, 64'h1012, 64'h0, "load_half_signed");
  endtask

  task automatic test_random();
    for (int a = 64'h1000; a < 64'h1048; a += 4) mem[longint'(a)] = $urandom;
    for (int n = 0; n < 60; n++)
      run_access(1'($urandom), 2'($urandom), 1'($urandom), 64'h1000 + 64'($urandom_range(0, 63)),
                 {$urandom, $urandom}, "random");
  endtask

  task automatic test_reset_mid();
    @(negedge iCLK);
    iReq = 1'b1; iWrite = 1'b0; iSize = 2'd3; iSigned = 1'b0; iAddr = 64'h1008;
    @(negedge iCLK);
    iReq = 1'b0;
    vectors++;
    if (oMemRead !== 1'b1 || oMemAddr !== 64'h1008) begin
      miscompares++; $display("FAIL rst_mid_issue0: rd=%b addr=%h want 1/1008", oMemRead, oMemAddr);
    end
    @(negedge iCLK);  // CAP0
    iMemRData = {32'h0, rd_mem(64'h1008)};
    iRST_n = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge iCLK);
      if (c == 1) iRST_n = 1'b1;
      vectors++;
      if (oDone !== 1'b0 || oMemRead !== 1'b0 || oMemWrite !== 1'b0) begin
        miscompares++; $display("FAIL rst_mid c%0d: done=%b rd=%b wr=%b want 0", c, oDone, oMemRead, oMemWrite);
      end
    end
    vectors++;
    if (oReady !== 1'b1 || oRData !== 64'h0) begin
      miscompares++; $display("FAIL rst_mid_final: ready=%b rdata=%h want 1/0", oReady, oRData);
    end
    last_rdata = '0;
  endtask

  task automatic test_back_to_back();
    logic [63:0] a;
    logic [31:0] d;
    a = 64'h1020 + 64'(4 * $urandom_range(0, 3));
    d = $urandom;
    @(negedge iCLK);
    iReq = 1'b1; iWrite = 1'b1; iSize = 2'd2; iSigned = 1'b0; iAddr = a; iWData = {32'h0, d};
    for (int c = 1; c <= 6; c++) begin
      @(negedge iCLK);
      vectors++;
      if (oMemWrite !== 1'((c == 1) || (c == 4)) || oDone !== 1'((c == 2) || (c == 5)) ||
          oReady !== 1'((c == 3) || (c == 6)) ||
          (oMemWrite === 1'b1 && (oMemAddr !== a || oMemWData[31:0] !== d))) begin
        miscompares++;
        $display("FAIL b2b c%0d: wr=%b done=%b ready=%b addr=%h wd=%h want wr=%b done=%b ready=%b addr=%h wd=%h",
                 c, oMemWrite, oDone, oReady, oMemAddr, oMemWData, (c == 1) || (c == 4),
                 (c == 2) || (c == 5), (c == 3) || (c == 6), a, d);
      end
      if (c == 6) iReq = 1'b0;
    end
    mem[longint'(a)] = d;
    @(negedge iCLK);
  endtask

  initial begin
    iRST_n = 1'b0; iReq = 1'b0; iWrite = 1'b0; iSize = 2'd0; iSigned = 1'b0;
    iAddr = '0; iWData = '0; iMemRData = '0;
    test_reset();
    test_directed();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
